// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, IR field positions,
// sequencer states and instruction classes.
package cpu_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_ROR  = 5'b00100;
  localparam logic [4:0] OP_ROL  = 5'b00101;
  localparam logic [4:0] OP_SHR  = 5'b00110;
  localparam logic [4:0] OP_SHRA = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01001;
  localparam logic [4:0] OP_DIV  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_MFHI = 5'b01101;
  localparam logic [4:0] OP_MFLO = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_ALU3,
    C_UNARY,
    C_MULDIV,
    C_MFHI,
    C_MFLO,
    C_NOP,
    C_HALT
  } iclass_e;

  // Group opcodes by their T3..T6 microsequence.
  // Undefined codes fall into the NOP class.
  function automatic iclass_e classify(
    input logic [4:0] opc
  );
    iclass_e c;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
      OP_SHL:           c = C_ALU3;
      OP_NEG, OP_NOT:   c = C_UNARY;
      OP_MUL, OP_DIV:   c = C_MULDIV;
      OP_MFHI:          c = C_MFHI;
      OP_MFLO:          c = C_MFLO;
      OP_HALT:          c = C_HALT;
      default:          c = C_NOP;
    endcase
    return c;
  endfunction

  // One-hot ALU select, bit 12 = ADD .. bit 0 = NOT.
  function automatic logic [12:0] alu_sel(
    input logic [4:0] opc
  );
    logic [12:0] s;
    case (opc)
      OP_ADD:  s = 13'h1000;
      OP_SUB:  s = 13'h0800;
      OP_AND:  s = 13'h0400;
      OP_OR:   s = 13'h0200;
      OP_ROR:  s = 13'h0100;
      OP_ROL:  s = 13'h0080;
      OP_SHR:  s = 13'h0040;
      OP_SHRA: s = 13'h0020;
      OP_SHL:  s = 13'h0010;
      OP_MUL:  s = 13'h0008;
      OP_DIV:  s = 13'h0004;
      OP_NEG:  s = 13'h0002;
      OP_NOT:  s = 13'h0001;
      default: s = 13'h0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reg_decode.sv
// 4-to-16 one-hot register select decoder.
// All outputs low when en is low.
module reg_decode
  import cpu_pkg::*;
(
  input  logic        en,
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  // Set the single selected bit when enabled.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0..T2 then
// per-class execute steps, Moore outputs.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        ROR,
  output logic        ROL,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        MUL,
  output logic        DIV,
  output logic        NEG,
  output logic        NOT,
  output logic        Read,
  output logic        Run
);

  state_e      state;
  state_e      next;
  iclass_e     cls;
  logic [4:0]  opc;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        rin_en;
  logic [3:0]  rin_idx;
  logic        rout_en;
  logic [3:0]  rout_idx;
  logic [12:0] alu;
  logic        unused_ir;

  assign opc = IR[OPC_MSB:OPC_LSB];
  assign ra  = IR[RA_MSB:RA_LSB];
  assign rb  = IR[RB_MSB:RB_LSB];
  assign rc  = IR[RC_MSB:RC_LSB];
  assign cls = classify(opc);
  assign unused_ir = ^IR[RC_LSB-1:0];

  assign {ADD, SUB, AND, OR, ROR, ROL, SHR,
          SHRA, SHL, MUL, DIV, NEG, NOT} = alu;

  // State register, clear forces RESET at once.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_RESET;
    else       state <= next;
  end

  // Next-state and Moore strobe decode.
  always_comb begin
    next     = state;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    HIout    = 1'b0;
    LOin     = 1'b0;
    LOout    = 1'b0;
    Read     = 1'b0;
    Run      = 1'b1;
    alu      = '0;
    rin_en   = 1'b0;
    rin_idx  = '0;
    rout_en  = 1'b0;
    rout_idx = '0;
    unique case (state)
      S_RESET: begin
        Run  = 1'b0;
        next = S_T0;
      end
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
        next  = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        case (cls)
          C_NOP:   next = S_T0;
          C_HALT:  next = S_HALT;
          default: next = S_T3;
        endcase
      end
      S_T3: begin
        next = S_T0;
        case (cls)
          C_ALU3: begin
            rout_en  = 1'b1;
            rout_idx = rb;
            Yin      = 1'b1;
            next     = S_T4;
          end
          C_UNARY: begin
            rout_en  = 1'b1;
            rout_idx = rb;
            alu      = alu_sel(opc);
            Zin      = 1'b1;
            next     = S_T4;
          end
          C_MULDIV: begin
            rout_en  = 1'b1;
            rout_idx = ra;
            Yin      = 1'b1;
            next     = S_T4;
          end
          C_MFHI: begin
            HIout   = 1'b1;
            rin_en  = 1'b1;
            rin_idx = ra;
          end
          C_MFLO: begin
            LOout   = 1'b1;
            rin_en  = 1'b1;
            rin_idx = ra;
          end
          default: next = S_T0;
        endcase
      end
      S_T4: begin
        next = S_T0;
        case (cls)
          C_ALU3: begin
            rout_en  = 1'b1;
            rout_idx = rc;
            alu      = alu_sel(opc);
            Zin      = 1'b1;
            next     = S_T5;
          end
          C_UNARY: begin
            Zlowout = 1'b1;
            rin_en  = 1'b1;
            rin_idx = ra;
          end
          C_MULDIV: begin
            rout_en  = 1'b1;
            rout_idx = rb;
            alu      = alu_sel(opc);
            Zin      = 1'b1;
            next     = S_T5;
          end
          default: next = S_T0;
        endcase
      end
      S_T5: begin
        next = S_T0;
        case (cls)
          C_ALU3: begin
            Zlowout = 1'b1;
            rin_en  = 1'b1;
            rin_idx = ra;
          end
          C_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
            next    = S_T6;
          end
          default: next = S_T0;
        endcase
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        next     = S_T0;
      end
      S_HALT: begin
        Run  = 1'b0;
        next = S_HALT;
      end
      default: begin
        Run  = 1'b0;
        next = S_RESET;
      end
    endcase
  end

  reg_decode u_rin (
    .en     (rin_en),
    .idx    (rin_idx),
    .onehot (Rin)
  );

  reg_decode u_rout (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer,
// outputs sampled on the falling clock edge.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic [31:0] IR;
  logic        mem_ready;
  logic [15:0] Rin, Rout;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout;
  logic IRin, Yin, Zin, Zlowout, Zhighout;
  logic HIin, HIout, LOin, LOout;
  logic ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA;
  logic SHL, MUL, DIV, NEG, NOT;
  logic Read, Run;

  int n_vec = 0;
  int n_err = 0;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR),
    .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
    .ROR(ROR), .ROL(ROL), .SHR(SHR), .SHRA(SHRA),
    .SHL(SHL), .MUL(MUL), .DIV(DIV), .NEG(NEG),
    .NOT(NOT), .Read(Read), .Run(Run)
  );

  logic [16:0] st;
  logic [12:0] alu;
  assign st = {PCout, PCin, IncPC, MARin, MDRin,
               MDRout, IRin, Yin, Zin, Zlowout,
               Zhighout, HIin, HIout, LOin, LOout,
               Read, Run};
  assign alu = {ADD, SUB, AND, OR, ROR, ROL, SHR,
                SHRA, SHL, MUL, DIV, NEG, NOT};

  localparam logic [16:0] B_PCOUT  = 17'h10000;
  localparam logic [16:0] B_PCIN   = 17'h08000;
  localparam logic [16:0] B_INCPC  = 17'h04000;
  localparam logic [16:0] B_MARIN  = 17'h02000;
  localparam logic [16:0] B_MDRIN  = 17'h01000;
  localparam logic [16:0] B_MDROUT = 17'h00800;
  localparam logic [16:0] B_IRIN   = 17'h00400;
  localparam logic [16:0] B_YIN    = 17'h00200;
  localparam logic [16:0] B_ZIN    = 17'h00100;
  localparam logic [16:0] B_ZLOW   = 17'h00080;
  localparam logic [16:0] B_ZHIGH  = 17'h00040;
  localparam logic [16:0] B_HIIN   = 17'h00020;
  localparam logic [16:0] B_HIOUT  = 17'h00010;
  localparam logic [16:0] B_LOIN   = 17'h00008;
  localparam logic [16:0] B_LOOUT  = 17'h00004;
  localparam logic [16:0] B_READ   = 17'h00002;
  localparam logic [16:0] B_RUN    = 17'h00001;

  localparam logic [16:0] E_T0 =
    B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam logic [16:0] E_T1 =
    B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [16:0] E_T2 =
    B_MDROUT | B_IRIN | B_RUN;

  localparam logic [12:0] A_ADD = 13'h1000;
  localparam logic [12:0] A_AND = 13'h0400;
  localparam logic [12:0] A_MUL = 13'h0008;
  localparam logic [12:0] A_NEG = 13'h0002;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic now_chk(
    input string       tag,
    input logic [16:0] es,
    input logic [12:0] ea,
    input logic [15:0] ei,
    input logic [15:0] eo
  );
    chk({tag, ".st"},   {15'd0, st},   {15'd0, es});
    chk({tag, ".alu"},  {19'd0, alu},  {19'd0, ea});
    chk({tag, ".rin"},  {16'd0, Rin},  {16'd0, ei});
    chk({tag, ".rout"}, {16'd0, Rout}, {16'd0, eo});
  endtask

  task automatic cyc(
    input string       tag,
    input logic [16:0] es,
    input logic [12:0] ea,
    input logic [15:0] ei,
    input logic [15:0] eo
  );
    @(negedge clock);
    now_chk(tag, es, ea, ei, eo);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".t1"}, E_T1, 0, 0, 0);
    cyc({tag, ".t2"}, E_T2, 0, 0, 0);
  endtask

  initial begin
    clear     = 1'b1;
    IR        = 32'h112B0000;
    mem_ready = 1'b1;
    #12;
    now_chk("rst", 0, 0, 0, 0);
    @(negedge clock);
    clear = 1'b0;

    // AND R2,R5,R6
    cyc("and.t0", E_T0, 0, 0, 0);
    fetch("and");
    cyc("and.t3", B_YIN | B_RUN, 0, 0, 16'h0020);
    cyc("and.t4", B_ZIN | B_RUN, A_AND, 0,
        16'h0040);
    cyc("and.t5", B_ZLOW | B_RUN, 0, 16'h0004, 0);
    cyc("and.t0b", E_T0, 0, 0, 0);

    // memory wait, NOP instruction
    mem_ready = 1'b0;
    IR = 32'hC0000000;
    for (int i = 0; i < 4; i++) begin
      cyc("wait.t1", E_T1, 0, 0, 0);
      if (i == 3) mem_ready = 1'b1;
    end
    cyc("wait.t2", E_T2, 0, 0, 0);
    cyc("wait.t0", E_T0, 0, 0, 0);

    // MUL R3,R1
    IR = 32'h49880000;
    fetch("mul");
    cyc("mul.t3", B_YIN | B_RUN, 0, 0, 16'h0008);
    cyc("mul.t4", B_ZIN | B_RUN, A_MUL, 0,
        16'h0002);
    cyc("mul.t5", B_ZLOW | B_LOIN | B_RUN, 0, 0, 0);
    cyc("mul.t6", B_ZHIGH | B_HIIN | B_RUN,
        0, 0, 0);
    cyc("mul.t0", E_T0, 0, 0, 0);

    // NEG R1,R2
    IR = {5'b01011, 4'd1, 4'd2, 19'd0};
    fetch("neg");
    cyc("neg.t3", B_ZIN | B_RUN, A_NEG, 0,
        16'h0004);
    cyc("neg.t4", B_ZLOW | B_RUN, 0, 16'h0002, 0);
    cyc("neg.t0", E_T0, 0, 0, 0);

    // MFHI R0
    IR = {5'b01101, 4'd0, 23'd0};
    fetch("mfhi");
    cyc("mfhi.t3", B_HIOUT | B_RUN, 0, 16'h0001, 0);
    cyc("mfhi.t0", E_T0, 0, 0, 0);

    // MFLO R15
    IR = {5'b01110, 4'd15, 23'd0};
    fetch("mflo");
    cyc("mflo.t3", B_LOOUT | B_RUN, 0, 16'h8000, 0);
    cyc("mflo.t0", E_T0, 0, 0, 0);

    // undefined opcode behaves as NOP
    IR = 32'hF8000000;
    fetch("undef");
    cyc("undef.t0", E_T0, 0, 0, 0);

    // ADD R7,R8,R9 cut by clear in T4
    IR = {5'b00000, 4'd7, 4'd8, 4'd9, 15'd0};
    fetch("addc");
    cyc("addc.t3", B_YIN | B_RUN, 0, 0, 16'h0100);
    cyc("addc.t4", B_ZIN | B_RUN, A_ADD, 0,
        16'h0200);
    clear = 1'b1;
    #1;
    now_chk("addc.clr", 0, 0, 0, 0);
    cyc("addc.hold", 0, 0, 0, 0);
    clear = 1'b0;
    cyc("addc.t0", E_T0, 0, 0, 0);

    // clear while waiting in T1
    IR = 32'hC0000000;
    mem_ready = 1'b0;
    cyc("t1c.a", E_T1, 0, 0, 0);
    cyc("t1c.b", E_T1, 0, 0, 0);
    clear = 1'b1;
    #1;
    now_chk("t1c.clr", 0, 0, 0, 0);
    @(negedge clock);
    clear = 1'b0;
    mem_ready = 1'b1;
    cyc("t1c.t0", E_T0, 0, 0, 0);

    // HALT holds until clear
    IR = 32'hC8000000;
    fetch("halt");
    for (int i = 0; i < 20; i++)
      cyc("halt.idle", 0, 0, 0, 0);
    clear = 1'b1;
    #1;
    now_chk("halt.clr", 0, 0, 0, 0);
    @(negedge clock);
    clear = 1'b0;
    cyc("halt.t0", E_T0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
